// File: rtl/test_mem_pkg.sv
// Shared types and sizes for the test memory arbiter.
// Requester bundles and sequencer states live here.
package test_mem_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/test_mem_rr_arb2.sv
// Two-input round-robin arbiter.
// The pointer moves to the other input after every grant.
module test_mem_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            req == 2'b11: gnt = ptr ? 2'b10 : 2'b01;
            req == 2'b01: gnt = 2'b01;
            req == 2'b10: gnt = 2'b10;
            default:      gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/test_mem_arbiter.sv
// Two-requester front end for a single-port test memory,
// with a sequencer that sweeps every word to CLEAR_VAL.
module test_mem_arbiter #(
    parameter int ADDR_W = test_mem_pkg::ADDR_W,
    parameter int DATA_W = test_mem_pkg::DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_val,
    output logic [1:0]        req_rdy,
    input  logic [1:0]        req_wr,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]        resp_val,
    input  logic [1:0]        resp_rdy,
    output logic [2*DATA_W-1:0] resp_data,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    import test_mem_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        elig;
    logic [1:0]        arb_req;
    logic [1:0]        fire;
    logic [1:0]        fresh;
    logic [1:0]        is_wr;
    logic [DATA_W-1:0] hold [NUM_REQ];
    mem_req_t          req  [NUM_REQ];
    mem_req_t          sel;

    // A clear request in IDLE takes priority over any pending request.
    assign elig    = ~resp_val | resp_rdy;
    assign arb_req = req_val & elig &
                     {2{(state == IDLE) && !clear_start}};
    assign fire    = req_val & req_rdy;

    test_mem_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .gnt   (req_rdy)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].wr   = req_wr[i];
            req[i].addr = req_addr[i*ADDR_W +: ADDR_W];
            req[i].data = req_data[i*DATA_W +: DATA_W];
        end
        sel = fire[1] ? req[1] : req[0];
    end

    always_comb begin
        read_en    = 1'b0;
        write_en   = 1'b0;
        read_addr  = sel.addr;
        write_addr = sel.addr;
        write_data = sel.data;
        if (state == CLEAR) begin
            write_en   = 1'b1;
            write_addr = cnt;
            write_data = CLEAR_VAL;
        end else if (|fire) begin
            read_en  = !sel.wr;
            write_en = sel.wr;
        end
    end

    // fresh marks the first response cycle, when read_data is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_val <= '0;
            fresh    <= '0;
            is_wr    <= '0;
            hold[0]  <= '0;
            hold[1]  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i]) begin
                    resp_val[i] <= 1'b1;
                    fresh[i]    <= 1'b1;
                    is_wr[i]    <= req_wr[i];
                end else begin
                    fresh[i] <= 1'b0;
                    if (resp_rdy[i]) begin
                        resp_val[i] <= 1'b0;
                    end
                end
                if (resp_val[i] && fresh[i] && !resp_rdy[i]) begin
                    hold[i] <= read_data;
                end
            end
        end
    end

    always_comb begin
        resp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_val[i] && !is_wr[i]) begin
                resp_data[i*DATA_W +: DATA_W] =
                    fresh[i] ? read_data : hold[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= DRAIN;
                        clear_busy <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (resp_val == 2'b00) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_mem_arbiter.sv
// Directed bench for test_mem_arbiter with a behavioural
// 1024 x 32 memory behind the command port.
module tb_test_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_val;
    logic [1:0]  req_rdy;
    logic [1:0]  req_wr;
    logic [19:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  resp_val;
    logic [1:0]  resp_rdy;
    logic [63:0] resp_data;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic        read_en;
    logic [9:0]  read_addr;
    logic        write_en;
    logic [9:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    logic [31:0] mem [1024];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    test_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_data   (resp_data),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_data   (read_data)
    );

    // Read data is garbage whenever read_en was low.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (write_en) mem[write_addr] <= write_data;
        if (read_en) read_data <= mem[read_addr];
        else read_data <= $urandom;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [9:0] a,
                            input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_read(input int r,
                           input logic [9:0] a,
                           input logic [31:0] exp,
                           input string tag);
        int n;
        cyc();
        req_val[r] = 1'b1;
        req_wr[r] = 1'b0;
        req_addr[r*10 +: 10] = a;
        resp_rdy = 2'b11;
        #1;
        n = 0;
        while (!req_rdy[r] && n < 8) begin
            cyc();
            n++;
        end
        if (n >= 8) chk({tag, "_timeout"}, 0, 1);
        cyc();
        req_val[r] = 1'b0;
        #1;
        chk(tag, resp_data[r*32 +: 32], exp);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_rdy"}, req_rdy, 0);
        chk({tag, "_resp_val"}, resp_val, 0);
        chk({tag, "_rd_wr_en"}, {read_en, write_en}, 0);
        chk({tag, "_busy_done"}, {clear_busy, clear_done}, 0);
    endtask

    logic [1:0] exp_gnt;
    int n;
    int bad;

    initial begin
        reset = 1'b1;
        req_val = '0;
        req_wr = '0;
        req_addr = '0;
        req_data = '0;
        resp_rdy = '0;
        clear_start = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;

        repeat (2) cyc();
        chk_reset_state("rst");
        bd_write(10'd5, 32'h1234);
        bd_write(10'd7, 32'd42);
        @(negedge clk);
        reset = 1'b0;

        // single read
        cyc();
        req_val = 2'b01;
        req_addr[9:0] = 10'd5;
        resp_rdy = 2'b11;
        #1;
        chk("rd_gnt", req_rdy, 2'b01);
        chk("rd_en", {read_en, write_en}, 2'b10);
        chk("rd_addr", read_addr, 10'd5);
        cyc();
        req_val = 2'b00;
        #1;
        chk("rd_val", resp_val, 2'b01);
        chk("rd_data", resp_data[31:0], 32'h1234);
        chk("rd_en_pulse", read_en, 0);
        cyc();
        chk("rd_val_drop", resp_val, 2'b00);

        // write then read at the top address
        req_val = 2'b10;
        req_wr = 2'b10;
        req_addr[19:10] = 10'd1023;
        req_data[63:32] = 32'hDEADBEEF;
        #1;
        chk("wr_gnt", req_rdy, 2'b10);
        chk("wr_en", {read_en, write_en}, 2'b01);
        chk("wr_addr", write_addr, 10'd1023);
        chk("wr_data", write_data, 32'hDEADBEEF);
        cyc();
        req_wr = 2'b00;
        #1;
        chk("wr_ack_val", resp_val, 2'b10);
        chk("wr_ack_data", resp_data[63:32], 0);
        chk("rb_gnt", req_rdy, 2'b10);
        cyc();
        req_val = 2'b00;
        #1;
        chk("rb_data", resp_data[63:32], 32'hDEADBEEF);

        // contention: pointer is back at 0
        cyc();
        req_val = 2'b11;
        req_addr = {10'd7, 10'd5};
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr_%0d", k), req_rdy, exp_gnt);
            cyc();
        end
        req_val = 2'b00;
        cyc();

        // response stall on requester 0
        req_val = 2'b01;
        req_addr = {10'd5, 10'd7};
        resp_rdy = 2'b10;
        #1;
        chk("st_gnt0", req_rdy, 2'b01);
        cyc();
        req_val = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("st_gnt1_%0d", k), req_rdy, 2'b10);
            chk($sformatf("st_hold_%0d", k),
                {resp_val[0], resp_data[31:0]}, {1'b1, 32'd42});
            if (k > 0) begin
                chk($sformatf("st_r1_%0d", k),
                    resp_data[63:32], 32'h1234);
            end
            cyc();
        end
        req_val = 2'b01;
        resp_rdy = 2'b11;
        #1;
        chk("st_release", req_rdy, 2'b01);
        chk("st_rel_data", resp_data[31:0], 32'd42);
        cyc();
        req_val = 2'b00;
        cyc();

        // clear with a pending response
        req_val = 2'b01;
        req_addr[9:0] = 10'd5;
        resp_rdy = 2'b00;
        #1;
        chk("cl_pend_gnt", req_rdy, 2'b01);
        cyc();
        req_val = 2'b10;
        clear_start = 1'b1;
        #1;
        chk("cl_wins", req_rdy, 2'b00);
        cyc();
        clear_start = 1'b0;
        #1;
        chk("cl_busy", clear_busy, 1);
        chk("cl_drain", {req_rdy, resp_val, write_en},
            {2'b00, 2'b01, 1'b0});
        cyc();
        resp_rdy = 2'b01;
        #1;
        n = 0;
        while (!write_en && n < 8) begin
            cyc();
            n++;
        end
        chk("cl_first_wr", write_en, 1);
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (!(write_en && write_addr == 10'(k) &&
                  write_data == 0 && resp_val == 0 &&
                  req_rdy == 0 && !read_en && !clear_done &&
                  clear_busy))
                bad++;
            if (k == 1023) req_val = 2'b00;
            cyc();
        end
        chk("cl_sweep_bad", bad, 0);
        chk("cl_done", {clear_done, clear_busy, write_en}, 3'b100);
        cyc();
        chk("cl_done_pulse", clear_done, 0);
        do_read(0, 10'd0, 32'd0, "cl_w0");
        do_read(1, 10'd1023, 32'd0, "cl_w1023");

        // reset in the middle of a sweep
        bd_write(10'd0, 32'h55);
        bd_write(10'd299, 32'h66);
        bd_write(10'd300, 32'h77);
        cyc();
        clear_start = 1'b1;
        cyc();
        clear_start = 1'b0;
        #1;
        n = 0;
        while (!(write_en && write_addr == 10'd300) && n < 1100) begin
            cyc();
            n++;
        end
        chk("mr_reach300", n < 1100, 1);
        reset = 1'b1;
        #1;
        chk_reset_state("mr");
        cyc();
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (clear_done || write_en) bad++;
        end
        chk("mr_no_done", bad, 0);
        do_read(0, 10'd0, 32'd0, "mr_w0");
        do_read(1, 10'd299, 32'd0, "mr_w299");
        do_read(0, 10'd300, 32'h77, "mr_w300");

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
